// File: rtl/dmem_pkg.sv
// dmem_pkg: types and constants shared by the data-memory responder and its array.
//   state_t     responder FSM states
//   op_t        latched access kind
//   IDX_W       word-index width for the default array depth
//   OPC_LW/SW   MIPS opcodes for load/store word, used when building stimulus
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    localparam int DEPTH_WORDS_DEF = 256;
    localparam int IDX_W           = $clog2(DEPTH_WORDS_DEF);
    localparam int CNT_W           = 4;

    localparam logic [5:0] OPC_LW = 6'b100011;
    localparam logic [5:0] OPC_SW = 6'b101011;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: synchronous single-port word RAM with a registered read port.
//   clk    clock, rising edge
//   we     write enable
//   idx    word index
//   wdata  write data
//   rdata  registered read data: mem[idx] as sampled on the previous edge
// Contents are not reset.
module dmem_array #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int IW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IW-1:0]     idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle word data memory behind the MEM-stage
// mem_read/mem_write strobes. Accepts a request in IDLE, waits LATENCY BUSY
// cycles, performs the access and pulses done for one cycle.
//   clk, rst           clock and asynchronous active-high reset
//   mem_read/mem_write load/store strobes (both set -> store)
//   addr, write_data   byte address and store data, sampled on acceptance
//   read_data          load data, updated only on load completion
//   stall              pipeline freeze while a request is outstanding
//   done, misalign     completion pulse, and misaligned-address flag with it
// Optional build macro DMEM_PERF_EN adds saturating rd_count / wr_count
// completion counters.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              stall,
    output logic              done,
`ifdef DMEM_PERF_EN
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
`endif
    output logic              misalign
);

    localparam int IW = $clog2(DEPTH_WORDS);

    state_t            state_q;
    op_t               op_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [IW-1:0]     idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic              mis_q;
    logic [DATA_W-1:0] read_data_q;

    logic              req;
    logic              complete;
    logic              arr_we;
    logic [IW-1:0]     arr_idx;
    logic [DATA_W-1:0] arr_rdata;

    // Bits above the word index are deliberately ignored (address wrap).
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[ADDR_W-1:2+IW];

    assign req      = mem_read | mem_write;
    assign complete = (state_q == BUSY) && (cnt_q == '0);
    assign arr_we   = complete && (op_q == OP_WR) && !mis_q;

    // The array read is registered, so it must be addressed one edge ahead of
    // completion. In IDLE that is the live address (matters for LATENCY=1),
    // afterwards the latched index.
    assign arr_idx = (state_q == IDLE) ? addr[2 +: IW] : idx_q;

    dmem_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IW          (IW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .idx   (arr_idx),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_RD;
            cnt_q       <= '0;
            idx_q       <= '0;
            wdata_q     <= '0;
            mis_q       <= 1'b0;
            read_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        op_q    <= mem_write ? OP_WR : OP_RD;
                        idx_q   <= addr[2 +: IW];
                        wdata_q <= write_data;
                        mis_q   <= (addr[1:0] != 2'b00);
                        cnt_q   <= CNT_W'(LATENCY - 1);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        if (op_q == OP_RD) begin
                            read_data_q <= mis_q ? '0 : arr_rdata;
                        end
                        state_q <= DONE;
                    end
                end
                // Strobes are still up here; they must not start a new access.
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        stall = 1'b0;
        case (state_q)
            IDLE:    stall = req;
            BUSY:    stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    assign done      = (state_q == DONE);
    assign misalign  = done & mis_q;
    assign read_data = read_data_q;

`ifdef DMEM_PERF_EN
    logic [15:0] rd_count_q;
    logic [15:0] wr_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else if (complete) begin
            if (op_q == OP_RD && rd_count_q != 16'hFFFF) begin
                rd_count_q <= rd_count_q + 16'd1;
            end
            if (op_q == OP_WR && wr_count_q != 16'hFFFF) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int LAT   = 2;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        stall;
    logic        done;
    logic        misalign;
`ifdef DMEM_PERF_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    dmem_responder #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data),
        .stall      (stall),
        .done       (done),
`ifdef DMEM_PERF_EN
        .rd_count   (rd_count),
        .wr_count   (wr_count),
`endif
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    // Reference model: memory as a plain word array, plus expected held load data.
    logic [31:0] mdl [DEPTH];
    logic [31:0] exp_rd;
    int          mdl_rd;
    int          mdl_wr;
    int          checks;
    int          errors;

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    // One complete access. Inputs change at posedge+1, outputs sampled there too.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input bit hold);
        int    stalls;
        bit    got;
        bit    is_wr;
        bit    mis;
        int    widx;
        logic [31:0] exp_data;
        is_wr = wr;
        mis   = (a % 4) != 0;
        widx  = (a / 4) % DEPTH;
        if (is_wr) begin
            if (!mis) mdl[widx] = d;
            mdl_wr++;
        end else begin
            exp_rd = mis ? 32'h0 : mdl[widx];
            mdl_rd++;
        end
        exp_data = exp_rd;
        mem_read = rd; mem_write = wr; addr = a; write_data = d;
        #1;
        stalls = 0;
        got    = 0;
        for (int i = 0; i < LAT + 10; i++) begin
            if (done) begin
                got = 1;
                break;
            end
            if (stall) stalls++;
            @(posedge clk); #1;
            // Inputs must be ignored once the request has been accepted.
            addr = $urandom; write_data = $urandom;
            if (!hold) begin mem_read = 0; mem_write = 0; end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL done_timeout addr=%h: no done within budget", a);
        end
        checks++;
        if (stalls !== LAT + 1) begin
            errors++;
            $display("FAIL stall_cycles addr=%h: got %0d want %0d", a, stalls, LAT + 1);
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL stall_in_done addr=%h: got %b want 0", a, stall);
        end
        checks++;
        if (misalign !== mis) begin
            errors++;
            $display("FAIL misalign addr=%h: got %b want %b", a, misalign, mis);
        end
        checks++;
        if (read_data !== exp_data) begin
            errors++;
            $display("FAIL read_data addr=%h wr=%b: got %h want %h", a, is_wr, read_data, exp_data);
        end
        mem_read = 0; mem_write = 0;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL after_done addr=%h: done=%b stall=%b want 0 0", a, done, stall);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (read_data !== 32'h0 || done !== 1'b0 || stall !== 1'b0 || misalign !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: rd=%h done=%b stall=%b mis=%b want 0", read_data, done, stall, misalign);
        end
`ifdef DMEM_PERF_EN
        checks++;
        if (rd_count !== 16'h0 || wr_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_counters: rd=%h wr=%h want 0 0", rd_count, wr_count);
        end
`endif
        rst = 0;
        exp_rd = 32'h0;
        // No request: nothing happens.
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (stall !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: stall=%b done=%b want 0 0", stall, done);
        end
    endtask

    task automatic test_preload;
        for (int w = 0; w < DEPTH; w++) begin
            access(1'b0, 1'b1, 32'(w * 4), $urandom, 1'b0);
        end
    endtask

    task automatic test_store_load;
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        checks++;
        if (read_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL store_load: got %h want DEADBEEF", read_data);
        end
    endtask

    task automatic test_misaligned;
        access(1'b0, 1'b1, 32'h13, 32'h12345678, 1'b0);
        access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        checks++;
        if (read_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL misaligned_store_kept: got %h want DEADBEEF", read_data);
        end
        access(1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
        checks++;
        if (read_data !== 32'h0) begin
            errors++;
            $display("FAIL misaligned_load_zero: got %h want 0", read_data);
        end
    endtask

    task automatic test_wrap;
        access(1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, 1'b0);
        access(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        checks++;
        if (read_data !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL wrap: got %h want A5A5A5A5", read_data);
        end
    endtask

    task automatic test_simultaneous;
        access(1'b1, 1'b1, 32'h20, 32'h11, 1'b1);
        access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
        checks++;
        if (read_data !== 32'h11) begin
            errors++;
            $display("FAIL simultaneous_is_write: got %h want 00000011", read_data);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] prior;
        prior = mdl[12];
        mem_write = 1; addr = 32'h30; write_data = 32'hFF;
        @(posedge clk); #1;
        mem_write = 0;
        @(posedge clk); #1;
        rst = 1;
        #1;
        checks++;
        if (stall !== 1'b0 || done !== 1'b0 || misalign !== 1'b0 || read_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: stall=%b done=%b mis=%b rd=%h want 0", stall, done, misalign, read_data);
        end
        @(posedge clk); #1;
        rst = 0;
        exp_rd = 32'h0;
        mdl_rd = 0;
        mdl_wr = 0;
        access(1'b1, 1'b0, 32'h30, 32'h0, 1'b0);
        checks++;
        if (read_data !== prior) begin
            errors++;
            $display("FAIL reset_mid_dropped: got %h want %h", read_data, prior);
        end
    endtask

    task automatic test_random;
        int          kind;
        logic [31:0] a;
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 2);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            access(kind != 1, kind != 0, a, $urandom, $urandom_range(0, 1) == 1);
        end
    endtask

`ifdef DMEM_PERF_EN
    task automatic test_perf;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        exp_rd = 32'h0;
        mdl_rd = 0;
        mdl_wr = 0;
        for (int k = 0; k < 3; k++) access(1'b1, 1'b0, 32'(k * 4), 32'h0, 1'b0);
        for (int k = 0; k < 2; k++) access(1'b0, 1'b1, 32'(k * 4 + 1), $urandom, 1'b0);
        checks++;
        if (rd_count !== 16'(sat16(mdl_rd)) || wr_count !== 16'(sat16(mdl_wr))) begin
            errors++;
            $display("FAIL perf_counts: rd=%0d wr=%0d want %0d %0d", rd_count, wr_count, mdl_rd, mdl_wr);
        end
        force dut.rd_count_q = 16'hFFFF;
        #1;
        release dut.rd_count_q;
        access(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
        checks++;
        if (rd_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL perf_saturate: got %h want FFFF", rd_count);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        mdl_rd = 0;
        mdl_wr = 0;
        exp_rd = 32'h0;
        test_reset();
        test_preload();
        test_store_load();
        test_misaligned();
        test_wrap();
        test_simultaneous();
        test_reset_mid();
        test_random();
`ifdef DMEM_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
